xava_data_arbiter: RTL and testbench

//  2:1 OBI data-port arbiter sharing the single mm_ram data port between the cv32e40x LSU
//  (requester 0, "core") and the XAVA vector unit load/store port (requester 1, "vec").
//  It serialises address phases, keeps each issued address phase stable until granted,
//  and routes in-order responses back to the issuing requester through a requester-ID FIFO.

---
 rtl/xava_data_arbiter.sv | 141 ++++++++++++++
 tb/tb_xava_data_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/xava_data_arbiter.sv
// 2:1 OBI data-port arbiter: core LSU (requester 0) and vector unit (requester 1) share one memory port.
// Address phases are held stable until granted; responses are routed in order via a requester-ID FIFO.
module xava_data_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit FIXED_PRIO      = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  input  logic        vec_req_i,
  output logic        vec_gnt_o,
  input  logic [31:0] vec_addr_i,
  input  logic        vec_we_i,
  input  logic [3:0]  vec_be_i,
  input  logic [31:0] vec_wdata_i,
  output logic        vec_rvalid_o,
  output logic [31:0] vec_rdata_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {ARB, HOLD_CORE, HOLD_VEC} state_t;

  state_t            state_reg, state_next;
  logic              sel_vec;
  logic              fire, pop, full, empty, head_vec;
  logic              prio_vec_reg;
  logic [31:0]       cap_addr_reg, cap_wdata_reg;
  logic              cap_we_reg;
  logic [3:0]        cap_be_reg;
  logic              id_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              err_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_reg == '0);

  always_comb begin
    state_next  = state_reg;
    sel_vec     = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = 32'h0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_wdata_o = 32'h0;
    case (state_reg)
      ARB: begin
        // A full ID FIFO blocks issue even if a response pops it this cycle.
        if (!full && (core_req_i || vec_req_i)) begin
          if (core_req_i && vec_req_i) sel_vec = FIXED_PRIO ? 1'b0 : prio_vec_reg;
          else                         sel_vec = vec_req_i;
          mem_req_o   = 1'b1;
          mem_addr_o  = sel_vec ? vec_addr_i  : core_addr_i;
          mem_we_o    = sel_vec ? vec_we_i    : core_we_i;
          mem_be_o    = sel_vec ? vec_be_i    : core_be_i;
          mem_wdata_o = sel_vec ? vec_wdata_i : core_wdata_i;
          if (!mem_gnt_i) state_next = sel_vec ? HOLD_VEC : HOLD_CORE;
        end
      end
      HOLD_CORE, HOLD_VEC: begin
        sel_vec     = (state_reg == HOLD_VEC);
        mem_req_o   = 1'b1;
        mem_addr_o  = cap_addr_reg;
        mem_we_o    = cap_we_reg;
        mem_be_o    = cap_be_reg;
        mem_wdata_o = cap_wdata_reg;
        if (mem_gnt_i) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  assign fire       = mem_req_o & mem_gnt_i;
  assign core_gnt_o = fire & ~sel_vec;
  assign vec_gnt_o  = fire & sel_vec;

  assign pop           = mem_rvalid_i & ~empty;
  assign head_vec      = id_fifo[rd_ptr_reg];
  assign core_rvalid_o = pop & ~head_vec;
  assign vec_rvalid_o  = pop & head_vec;
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : 32'h0;
  assign vec_rdata_o   = vec_rvalid_o  ? mem_rdata_i : 32'h0;
  assign err_o         = err_reg;

  always_ff @(posedge clk_i) begin
    if (fire) id_fifo[wr_ptr_reg] <= sel_vec;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ARB;
      prio_vec_reg  <= 1'b0;
      cap_addr_reg  <= 32'h0;
      cap_we_reg    <= 1'b0;
      cap_be_reg    <= 4'h0;
      cap_wdata_reg <= 32'h0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ARB && mem_req_o) begin
        cap_addr_reg  <= mem_addr_o;
        cap_we_reg    <= mem_we_o;
        cap_be_reg    <= mem_be_o;
        cap_wdata_reg <= mem_wdata_o;
      end
      // Round-robin: the requester not granted last wins the next tie.
      if (fire) begin
        prio_vec_reg <= ~sel_vec;
        wr_ptr_reg   <= ptr_inc(wr_ptr_reg);
      end
      if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (fire && !pop)      count_reg <= count_reg + 1'b1;
      else if (!fire && pop) count_reg <= count_reg - 1'b1;
      if (mem_rvalid_i && empty) err_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_xava_data_arbiter.sv
// Directed bench for xava_data_arbiter: round-robin instance plus a fixed-priority
// instance sharing the same stimulus.
module tb_xava_data_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        core_req, core_we, vec_req, vec_we, mem_gnt, mem_rvalid;
  logic [31:0] core_addr, core_wdata, vec_addr, vec_wdata, mem_rdata;
  logic [3:0]  core_be, vec_be;

  logic        core_gnt, core_rvalid, vec_gnt, vec_rvalid, mem_req, mem_we, err;
  logic [31:0] core_rdata, vec_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        fp_core_gnt, fp_core_rvalid, fp_vec_gnt, fp_vec_rvalid, fp_mem_req, fp_mem_we, fp_err;
  logic [31:0] fp_core_rdata, fp_vec_rdata, fp_mem_addr, fp_mem_wdata;
  logic [3:0]  fp_mem_be;

  int total = 0;
  int bad   = 0;

  xava_data_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_gnt_o(core_gnt), .core_addr_i(core_addr), .core_we_i(core_we),
    .core_be_i(core_be), .core_wdata_i(core_wdata), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .vec_req_i(vec_req), .vec_gnt_o(vec_gnt), .vec_addr_i(vec_addr), .vec_we_i(vec_we),
    .vec_be_i(vec_be), .vec_wdata_i(vec_wdata), .vec_rvalid_o(vec_rvalid), .vec_rdata_o(vec_rdata),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .err_o(err)
  );

  xava_data_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b1)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_gnt_o(fp_core_gnt), .core_addr_i(core_addr), .core_we_i(core_we),
    .core_be_i(core_be), .core_wdata_i(core_wdata), .core_rvalid_o(fp_core_rvalid), .core_rdata_o(fp_core_rdata),
    .vec_req_i(vec_req), .vec_gnt_o(fp_vec_gnt), .vec_addr_i(vec_addr), .vec_we_i(vec_we),
    .vec_be_i(vec_be), .vec_wdata_i(vec_wdata), .vec_rvalid_o(fp_vec_rvalid), .vec_rdata_o(fp_vec_rdata),
    .mem_req_o(fp_mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(fp_mem_addr), .mem_we_o(fp_mem_we),
    .mem_be_o(fp_mem_be), .mem_wdata_o(fp_mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .err_o(fp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    core_req = 0; core_we = 0; core_be = 4'hf; core_addr = 0; core_wdata = 0;
    vec_req = 0;  vec_we = 0;  vec_be = 4'hf;  vec_addr = 0;  vec_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_mem_req", 32'(mem_req), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_core_gnt", 32'(core_gnt), 32'h0);
    $display("reset: mem_req=%0b err=%0b", mem_req, err);

    // 1: core-only read, immediate grant, response next cycle
    tick();
    core_req = 1; core_addr = 32'h1000; mem_gnt = 1;
    #1;
    check("t1_core_gnt", 32'(core_gnt), 32'h1);
    check("t1_vec_gnt", 32'(vec_gnt), 32'h0);
    check("t1_mem_addr", mem_addr, 32'h1000);
    $display("t1 grant: core_gnt=%0b mem_addr=%h", core_gnt, mem_addr);
    tick();
    core_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    check("t1_core_rvalid", 32'(core_rvalid), 32'h1);
    check("t1_core_rdata", core_rdata, 32'hDEADBEEF);
    check("t1_vec_rvalid", 32'(vec_rvalid), 32'h0);
    check("t1_vec_rdata", vec_rdata, 32'h0);
    $display("t1 resp: core_rvalid=%0b rdata=%h", core_rvalid, core_rdata);
    tick();
    mem_rvalid = 0;

    // 2: both request every cycle; core was granted last, so RR starts with vec
    core_req = 1; vec_req = 1; mem_gnt = 1;
    core_addr = 32'h100; vec_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = (i != 0);
      mem_rdata  = 32'hA0 + 32'(i);
      #1;
      check("t2_vec_gnt", 32'(vec_gnt), 32'((i % 2) == 0));
      check("t2_core_gnt", 32'(core_gnt), 32'((i % 2) == 1));
      check("t2_mem_addr", mem_addr, ((i % 2) == 0) ? 32'h200 : 32'h100);
      check("t2_fp_core_gnt", 32'(fp_core_gnt), 32'h1);
      check("t2_fp_vec_gnt", 32'(fp_vec_gnt), 32'h0);
      if (i != 0) begin
        check("t2_vec_rvalid", 32'(vec_rvalid), 32'((i % 2) == 1));
        check("t2_core_rvalid", 32'(core_rvalid), 32'((i % 2) == 0));
        check("t2_fp_core_rvalid", 32'(fp_core_rvalid), 32'h1);
      end
      $display("t2 cycle %0d: rr core=%0b vec=%0b fp core=%0b vec=%0b", i, core_gnt, vec_gnt, fp_core_gnt, fp_vec_gnt);
      tick();
    end
    core_req = 0; vec_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    #1;
    check("t2_drain_core_rvalid", 32'(core_rvalid), 32'h1);
    check("t2_drain_core_rdata", core_rdata, 32'h77);
    check("t2_drain_fp_core_rvalid", 32'(fp_core_rvalid), 32'h1);
    $display("t2 drain: core_rvalid=%0b", core_rvalid);
    tick();
    mem_rvalid = 0;

    // 3: vec write held for 3 cycles while vec changes address and core requests
    vec_req = 1; vec_we = 1; vec_be = 4'b0011; vec_addr = 32'h2000; vec_wdata = 32'h55AA;
    #1;
    check("t3_mem_req", 32'(mem_req), 32'h1);
    check("t3_mem_addr0", mem_addr, 32'h2000);
    check("t3_mem_be", 32'(mem_be), 32'h3);
    check("t3_mem_we", 32'(mem_we), 32'h1);
    check("t3_vec_gnt0", 32'(vec_gnt), 32'h0);
    $display("t3 issue: mem_addr=%h be=%h", mem_addr, mem_be);
    tick();
    vec_addr = 32'h3000; vec_be = 4'hf; vec_wdata = 32'h0;
    core_req = 1; core_we = 0; core_addr = 32'h4000;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t3_hold_addr", mem_addr, 32'h2000);
      check("t3_hold_be", 32'(mem_be), 32'h3);
      check("t3_hold_wdata", mem_wdata, 32'h55AA);
      check("t3_hold_core_gnt", 32'(core_gnt), 32'h0);
      $display("t3 hold %0d: mem_req=%0b mem_addr=%h core_gnt=%0b", i, mem_req, mem_addr, core_gnt);
      tick();
    end
    mem_gnt = 1;
    #1;
    check("t3_vec_gnt", 32'(vec_gnt), 32'h1);
    check("t3_core_gnt", 32'(core_gnt), 32'h0);
    check("t3_gnt_addr", mem_addr, 32'h2000);
    $display("t3 grant: vec_gnt=%0b mem_addr=%h", vec_gnt, mem_addr);
    tick();
    vec_req = 0;
    #1;
    check("t3_core_after", 32'(core_gnt), 32'h1);
    check("t3_core_addr", mem_addr, 32'h4000);
    $display("t3 core: core_gnt=%0b mem_addr=%h", core_gnt, mem_addr);
    tick();

    // 4: FIFO now holds vec,core (full); core keeps requesting
    #1;
    check("t4_full_mem_req", 32'(mem_req), 32'h0);
    check("t4_full_core_gnt", 32'(core_gnt), 32'h0);
    $display("t4 full: mem_req=%0b", mem_req);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h1111;
    #1;
    check("t4_nobypass_mem_req", 32'(mem_req), 32'h0);
    check("t4_vec_rvalid", 32'(vec_rvalid), 32'h1);
    check("t4_vec_rdata", vec_rdata, 32'h1111);
    check("t4_core_rvalid0", 32'(core_rvalid), 32'h0);
    $display("t4 pop: vec_rvalid=%0b mem_req=%0b", vec_rvalid, mem_req);
    tick();
    mem_rvalid = 0;
    #1;
    check("t4_resume_core_gnt", 32'(core_gnt), 32'h1);
    $display("t4 resume: core_gnt=%0b", core_gnt);
    tick();
    core_req = 0; mem_gnt = 0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1; mem_rdata = 32'h2220 + 32'(i);
      #1;
      check("t4_core_rvalid", 32'(core_rvalid), 32'h1);
      check("t4_core_rdata", core_rdata, 32'h2220 + 32'(i));
      check("t4_vec_rvalid", 32'(vec_rvalid), 32'h0);
      $display("t4 resp %0d: core_rvalid=%0b rdata=%h", i, core_rvalid, core_rdata);
      tick();
    end
    mem_rvalid = 0;

    // 5: spurious response, then reset in the middle of a HOLD
    mem_rvalid = 1; mem_rdata = 32'h9999;
    #1;
    check("t5_spur_core_rvalid", 32'(core_rvalid), 32'h0);
    check("t5_spur_vec_rvalid", 32'(vec_rvalid), 32'h0);
    tick();
    mem_rvalid = 0;
    #1;
    check("t5_err_set", 32'(err), 32'h1);
    $display("t5 spurious: err=%0b", err);
    tick();
    #1;
    check("t5_err_sticky", 32'(err), 32'h1);
    core_req = 1; core_addr = 32'h5000; mem_gnt = 1;
    tick();
    mem_gnt = 0;
    tick();
    #1;
    check("t5_hold_mem_req", 32'(mem_req), 32'h1);
    rst = 1;
    tick();
    rst = 0; core_req = 0;
    #1;
    check("t5_rst_mem_req", 32'(mem_req), 32'h0);
    check("t5_rst_err", 32'(err), 32'h0);
    $display("t5 reset: mem_req=%0b err=%0b", mem_req, err);
    tick();
    mem_rvalid = 1;
    #1;
    check("t5_empty_core_rvalid", 32'(core_rvalid), 32'h0);
    tick();
    mem_rvalid = 0;
    #1;
    check("t5_empty_err", 32'(err), 32'h1);
    $display("t5 post-reset rvalid: err=%0b", err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
